// File: rtl/frame_tx_scheduler_pkg.sv
// Shared constants for the frame scheduler and the framing encoder it drives.
// State encodings are plain localparams so older tools can share them unchanged.
package frame_tx_scheduler_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_WAIT_RX = 3'd2;
   localparam logic [2:0] ST_WAIT_TX = 3'd3;
   localparam logic [2:0] ST_TAIL    = 3'd4;

   // Encoder geometry; the encoder itself is built from these same values.
   localparam int LEFT_PAD    = 80;
   localparam int BIT_CYCLES  = 8;
   localparam int TAIL_CYCLES = 16;
   localparam int MAX_BYTES   = 20;

endpackage

// File: rtl/frame_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer, wrapping cyclically.
module rr_arbiter
   import frame_tx_scheduler_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int SRC_W = 2
) (
   input  logic [N_SRC-1:0] req_i,
   input  logic [SRC_W-1:0] ptr_i,
   output logic [N_SRC-1:0] gnt_o,
   output logic [SRC_W-1:0] idx_o,
   output logic             valid_o
);

   int   cand;
   logic found;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 0; k < N_SRC; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= N_SRC) cand = cand - N_SRC;
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand[SRC_W-1:0];
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/frame_tx_scheduler.sv
// Shares one framing encoder between N_SRC sources: round-robin grant, one
// contiguous byte burst per frame, then waits out both indicators and padding.
module frame_tx_scheduler #(
   parameter int N_SRC       = 4,
   parameter int SRC_W       = 2,
   parameter int MAX_BYTES   = frame_tx_scheduler_pkg::MAX_BYTES,
   parameter int TAIL_CYCLES = frame_tx_scheduler_pkg::TAIL_CYCLES,
   parameter int TIMEOUT     = 2048
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_SRC-1:0]   src_req,
   input  logic [8*N_SRC-1:0] src_data,
   input  logic [N_SRC-1:0]   src_last,
   output logic [N_SRC-1:0]   src_pop,
   output logic [SRC_W-1:0]   grant_id,
   output logic [7:0]         enc_din,
   output logic               enc_din_valid,
   input  logic               enc_indicator,
   output logic               busy,
   output logic               frame_done,
   output logic               frame_err
);
   import frame_tx_scheduler_pkg::*;

   localparam int CNT_W = $clog2(MAX_BYTES + 1);
   localparam int TMR_W = $clog2(TIMEOUT);

   logic [2:0]       state_q,    state_d;
   logic [SRC_W-1:0] grant_q,    grant_d;
   logic [N_SRC-1:0] grantOh_q,  grantOh_d;
   logic [SRC_W-1:0] rrPtr_q,    rrPtr_d;
   logic [CNT_W-1:0] byteCnt_q,  byteCnt_d;
   logic [TMR_W-1:0] timer_q,    timer_d;
   logic             trunc_q,    trunc_d;
   logic [7:0]       din_q,      din_d;
   logic             dinValid_q, dinValid_d;
   logic             done_q,     done_d;
   logic             err_q,      err_d;

   logic [N_SRC-1:0] arbGnt;
   logic [SRC_W-1:0] arbIdx;
   logic             arbValid;
   logic             grantReq;
   logic             grantLast;

   rr_arbiter #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_arb (
      .req_i   (src_req),
      .ptr_i   (rrPtr_q),
      .gnt_o   (arbGnt),
      .idx_o   (arbIdx),
      .valid_o (arbValid)
   );

   assign grantReq  = |(src_req & grantOh_q);
   assign grantLast = |(src_last & grantOh_q);

   // A source dropping its request mid-frame ends the burst without a pop and
   // is reported as truncated, so no undefined byte reaches the encoder.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grantOh_d  = grantOh_q;
      rrPtr_d    = rrPtr_q;
      byteCnt_d  = byteCnt_q;
      timer_d    = timer_q;
      trunc_d    = trunc_q;
      din_d      = '0;
      dinValid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      src_pop    = '0;
      case (state_q)
         ST_IDLE: begin
            byteCnt_d = '0;
            timer_d   = '0;
            if (arbValid) begin
               grant_d   = arbIdx;
               grantOh_d = arbGnt;
               rrPtr_d   = (arbIdx == SRC_W'(N_SRC - 1)) ? '0 : arbIdx + 1'b1;
               trunc_d   = 1'b0;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            timer_d = '0;
            if (grantReq) begin
               src_pop    = grantOh_q;
               din_d      = src_data[{grant_q, 3'b000} +: 8];
               dinValid_d = 1'b1;
               byteCnt_d  = byteCnt_q + 1'b1;
               if (grantLast) begin
                  state_d = ST_WAIT_RX;
               end else if (byteCnt_q == CNT_W'(MAX_BYTES - 1)) begin
                  state_d = ST_WAIT_RX;
                  trunc_d = 1'b1;
               end
            end else begin
               state_d = ST_WAIT_RX;
               trunc_d = 1'b1;
            end
         end
         ST_WAIT_RX, ST_WAIT_TX: begin
            if (enc_indicator) begin
               state_d = (state_q == ST_WAIT_RX) ? ST_WAIT_TX : ST_TAIL;
               timer_d = '0;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_TAIL: begin
            if (timer_q == TMR_W'(TAIL_CYCLES - 1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               err_d   = trunc_q;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         grantOh_q  <= '0;
         rrPtr_q    <= '0;
         byteCnt_q  <= '0;
         timer_q    <= '0;
         trunc_q    <= 1'b0;
         din_q      <= '0;
         dinValid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grantOh_q  <= grantOh_d;
         rrPtr_q    <= rrPtr_d;
         byteCnt_q  <= byteCnt_d;
         timer_q    <= timer_d;
         trunc_q    <= trunc_d;
         din_q      <= din_d;
         dinValid_q <= dinValid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign grant_id      = grant_q;
   assign enc_din       = din_q;
   assign enc_din_valid = dinValid_q;
   assign frame_done    = done_q;
   assign frame_err     = err_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Self-checking bench: byte/frame scoreboard, source FIFO models and a simple
// encoder model that raises indicator #1 after the burst and #2 a bit later.
module tb_frame_tx_scheduler;

   localparam int N        = 4;
   localparam int TAIL     = 16;
   localparam int TIMEOUT  = 2048;
   localparam int MAXB     = 20;
   localparam int TX_DELAY = 12;

   typedef struct packed {logic [1:0] id; logic [7:0] data;} byteExp_t;
   typedef struct packed {logic [1:0] id; logic done; logic err;} frameExp_t;

   logic           clk;
   logic           reset_n;
   logic [N-1:0]   src_req;
   logic [8*N-1:0] src_data;
   logic [N-1:0]   src_last;
   logic [N-1:0]   src_pop;
   logic [1:0]     grant_id;
   logic [7:0]     enc_din;
   logic           enc_din_valid;
   logic           enc_indicator;
   logic           busy;
   logic           frame_done;
   logic           frame_err;

   int tests = 0;
   int fails = 0;
   int cycle = 0;

   byteExp_t  expBytes[$];
   frameExp_t expFrames[$];

   logic [8:0] srcMem [N][64];
   int         srcHead [N];
   int         srcTail [N];
   logic [N-1:0] pendingPop;

   int  popCnt [N];
   int  validCnt, validRuns, lastValidCycle, lastEvtCycle, ind2Cycle;
   logic prevMonValid, prevValid;
   int  txCnt;
   bit  encEn;

   frame_tx_scheduler #(
      .N_SRC(N), .SRC_W(2), .MAX_BYTES(MAXB), .TAIL_CYCLES(TAIL), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .src_req       (src_req),
      .src_data      (src_data),
      .src_last      (src_last),
      .src_pop       (src_pop),
      .grant_id      (grant_id),
      .enc_din       (enc_din),
      .enc_din_valid (enc_din_valid),
      .enc_indicator (enc_indicator),
      .busy          (busy),
      .frame_done    (frame_done),
      .frame_err     (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   task automatic driveSources();
      for (int i = 0; i < N; i++) begin
         if (srcTail[i] > srcHead[i]) begin
            src_req[i]         = 1'b1;
            src_data[8*i +: 8] = srcMem[i][srcHead[i]][7:0];
            src_last[i]        = srcMem[i][srcHead[i]][8];
         end else begin
            src_req[i]         = 1'b0;
            src_data[8*i +: 8] = 8'h00;
            src_last[i]        = 1'b0;
         end
      end
   endtask

   // Bytes are base + k*0x11, so base A1 gives A1, B2, C3, ...
   task automatic addFrame(input int src, input int len, input logic [7:0] base, input int lastPos);
      for (int k = 0; k < len; k++) begin
         srcMem[src][srcTail[src]] = {(k == lastPos), base + 8'(k * 17)};
         srcTail[src]++;
      end
      driveSources();
   endtask

   task automatic expectFrame(input int src, input int first, input int nBytes,
                              input logic [7:0] base, input logic done, input logic err);
      byteExp_t b;
      frameExp_t f;
      for (int k = first; k < first + nBytes; k++) begin
         b.id   = 2'(src);
         b.data = base + 8'(k * 17);
         expBytes.push_back(b);
      end
      f.id   = 2'(src);
      f.done = done;
      f.err  = err;
      expFrames.push_back(f);
   endtask

   // Source FIFOs advance just after the edge on which the DUT popped them.
   initial begin
      pendingPop = '0;
      forever begin
         @(negedge clk);
         pendingPop = src_pop;
         @(posedge clk);
         #1;
         if (reset_n)
            for (int i = 0; i < N; i++)
               if (pendingPop[i]) srcHead[i]++;
         driveSources();
      end
   end

   // Encoder model: indicator #1 in the first cycle din_valid is low,
   // indicator #2 TX_DELAY cycles later.
   initial begin
      enc_indicator = 1'b0;
      prevValid     = 1'b0;
      txCnt         = 0;
      forever begin
         @(negedge clk);
         enc_indicator = 1'b0;
         if (!reset_n) begin
            prevValid = 1'b0;
            txCnt     = 0;
         end else begin
            if (txCnt > 0) begin
               txCnt--;
               if (txCnt == 0) begin
                  enc_indicator = 1'b1;
                  ind2Cycle     = cycle;
               end
            end
            if (prevValid && !enc_din_valid && encEn) begin
               enc_indicator = 1'b1;
               txCnt         = TX_DELAY;
            end
            prevValid = enc_din_valid;
         end
      end
   end

   // Scoreboard consumer: every byte and every frame outcome is popped here.
   always @(negedge clk) begin
      if (reset_n) begin
         if (src_pop != '0) begin
            popCnt[grant_id]++;
            tests++;
            if (src_pop !== (4'b0001 << grant_id)) begin
               fails++;
               $display("[TB] FAIL pop_onehot: got %b expected %b", src_pop, 4'b0001 << grant_id);
            end
         end
         if (enc_din_valid) begin
            validCnt++;
            if (!prevMonValid) validRuns++;
            lastValidCycle = cycle;
            tests++;
            if (expBytes.size() == 0) begin
               fails++;
               $display("[TB] FAIL byte_unexpected: got id %0d data %h expected none", grant_id, enc_din);
            end else begin
               byteExp_t e;
               e = expBytes.pop_front();
               if (enc_din !== e.data || grant_id !== e.id) begin
                  fails++;
                  $display("[TB] FAIL byte: got id %0d data %h expected id %0d data %h",
                           grant_id, enc_din, e.id, e.data);
               end
            end
         end
         prevMonValid = enc_din_valid;
         if (frame_done || frame_err) begin
            lastEvtCycle = cycle;
            tests++;
            if (expFrames.size() == 0) begin
               fails++;
               $display("[TB] FAIL frame_unexpected: got id %0d done %b err %b expected none",
                        grant_id, frame_done, frame_err);
            end else begin
               frameExp_t f;
               f = expFrames.pop_front();
               if (grant_id !== f.id || frame_done !== f.done || frame_err !== f.err) begin
                  fails++;
                  $display("[TB] FAIL frame: got id %0d done %b err %b expected id %0d done %b err %b",
                           grant_id, frame_done, frame_err, f.id, f.done, f.err);
               end
            end
         end
      end else begin
         prevMonValid = 1'b0;
      end
   end

   task automatic startReset();
      reset_n = 1'b0;
      encEn   = 1'b1;
      for (int i = 0; i < N; i++) begin
         srcHead[i] = 0;
         srcTail[i] = 0;
         popCnt[i]  = 0;
      end
      expBytes.delete();
      expFrames.delete();
      validCnt  = 0;
      validRuns = 0;
      driveSources();
      repeat (2) @(negedge clk);
   endtask

   task automatic releaseReset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic waitFrames(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         #1;
         if (expFrames.size() == target && (target > 0 || expBytes.size() == 0)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      startReset();
      #1;
      tests += 7;
      if (src_pop !== 4'b0)       begin fails++; $display("[TB] FAIL reset_pop: got %b expected 0", src_pop); end
      if (grant_id !== 2'd0)      begin fails++; $display("[TB] FAIL reset_grant: got %0d expected 0", grant_id); end
      if (enc_din !== 8'h00)      begin fails++; $display("[TB] FAIL reset_din: got %h expected 00", enc_din); end
      if (enc_din_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", enc_din_valid); end
      if (busy !== 1'b0)          begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      if (frame_done !== 1'b0)    begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", frame_done); end
      if (frame_err !== 1'b0)     begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", frame_err); end
      releaseReset();
   endtask

   task automatic test_single_frame();
      bit ok;
      startReset();
      releaseReset();
      addFrame(1, 3, 8'hA1, 2);
      expectFrame(1, 0, 3, 8'hA1, 1'b1, 1'b0);
      waitFrames(0, 300, ok);
      tests += 5;
      if (!ok) begin fails++; $display("[TB] FAIL single_timeout: got pending %0d expected 0", expFrames.size()); end
      if (popCnt[1] != 3) begin fails++; $display("[TB] FAIL single_pops: got %0d expected 3", popCnt[1]); end
      if (validCnt != 3 || validRuns != 1) begin
         fails++; $display("[TB] FAIL single_burst: got %0d bytes in %0d runs expected 3 in 1", validCnt, validRuns);
      end
      if (popCnt[0] + popCnt[2] + popCnt[3] != 0) begin
         fails++; $display("[TB] FAIL single_other_pops: got %0d expected 0", popCnt[0] + popCnt[2] + popCnt[3]);
      end
      // frame_done is registered on the edge TAIL cycles after the one capturing indicator #2
      if (lastEvtCycle - ind2Cycle != TAIL + 1) begin
         fails++; $display("[TB] FAIL single_tail: got %0d expected %0d", lastEvtCycle - ind2Cycle, TAIL + 1);
      end
   endtask

   task automatic test_round_robin_all();
      bit ok;
      startReset();
      for (int i = 0; i < N; i++) begin
         addFrame(i, 1, 8'(8'h10 * (i + 1)), 0);
         expectFrame(i, 0, 1, 8'(8'h10 * (i + 1)), 1'b1, 1'b0);
      end
      releaseReset();
      waitFrames(0, 1000, ok);
      tests += 2;
      if (!ok) begin fails++; $display("[TB] FAIL rr_all_timeout: got pending %0d expected 0", expFrames.size()); end
      if (validCnt != 4 || validRuns != 4) begin
         fails++; $display("[TB] FAIL rr_all_bursts: got %0d bytes in %0d runs expected 4 in 4", validCnt, validRuns);
      end
      for (int i = 0; i < N; i++) begin
         tests++;
         if (popCnt[i] != 1) begin fails++; $display("[TB] FAIL rr_all_pops%0d: got %0d expected 1", i, popCnt[i]); end
      end
   endtask

   task automatic test_truncation();
      bit ok;
      startReset();
      releaseReset();
      addFrame(2, 25, 8'h05, 24);
      expectFrame(2, 0, MAXB, 8'h05, 1'b1, 1'b1);
      expectFrame(2, MAXB, 5, 8'h05, 1'b1, 1'b0);
      waitFrames(1, 500, ok);
      tests += 3;
      if (!ok) begin fails++; $display("[TB] FAIL trunc_timeout: got pending %0d expected 1", expFrames.size()); end
      if (popCnt[2] != MAXB || validCnt != MAXB) begin
         fails++; $display("[TB] FAIL trunc_count: got %0d pops %0d bytes expected %0d", popCnt[2], validCnt, MAXB);
      end
      if (srcTail[2] - srcHead[2] != 5) begin
         fails++; $display("[TB] FAIL trunc_retained: got %0d expected 5", srcTail[2] - srcHead[2]);
      end
      waitFrames(0, 500, ok);
      tests += 2;
      if (!ok) begin fails++; $display("[TB] FAIL trunc_rest_timeout: got pending %0d expected 0", expFrames.size()); end
      if (popCnt[2] != 25) begin fails++; $display("[TB] FAIL trunc_total_pops: got %0d expected 25", popCnt[2]); end
   endtask

   task automatic test_timeout();
      bit ok;
      int waited;
      startReset();
      releaseReset();
      encEn = 1'b0;
      addFrame(1, 2, 8'h31, 1);
      addFrame(2, 1, 8'h77, 0);
      expectFrame(1, 0, 2, 8'h31, 1'b0, 1'b1);
      expectFrame(2, 0, 1, 8'h77, 1'b1, 1'b0);
      waited = 0;
      while (!(validCnt == 2 && !enc_din_valid) && waited < 100) begin
         @(negedge clk);
         #1;
         waited++;
      end
      encEn = 1'b1;
      waitFrames(1, TIMEOUT + 200, ok);
      tests += 3;
      if (!ok) begin fails++; $display("[TB] FAIL timeout_wait: got pending %0d expected 1", expFrames.size()); end
      if (lastEvtCycle - lastValidCycle != TIMEOUT) begin
         fails++; $display("[TB] FAIL timeout_len: got %0d expected %0d", lastEvtCycle - lastValidCycle, TIMEOUT);
      end
      if (busy !== 1'b0) begin fails++; $display("[TB] FAIL timeout_busy: got %b expected 0", busy); end
      waitFrames(0, 500, ok);
      tests++;
      if (!ok) begin fails++; $display("[TB] FAIL timeout_next: got pending %0d expected 0", expFrames.size()); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int waited;
      startReset();
      releaseReset();
      addFrame(0, 2, 8'h40, 1);
      expectFrame(0, 0, 2, 8'h40, 1'b1, 1'b0);
      waited = 0;
      while (popCnt[0] < 1 && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      addFrame(3, 1, 8'h90, 0);
      addFrame(0, 1, 8'h50, 0);
      expectFrame(3, 0, 1, 8'h90, 1'b1, 1'b0);
      expectFrame(0, 0, 1, 8'h50, 1'b1, 1'b0);
      waitFrames(0, 1000, ok);
      tests += 2;
      if (!ok) begin fails++; $display("[TB] FAIL b2b_timeout: got pending %0d expected 0", expFrames.size()); end
      if (popCnt[0] != 3 || popCnt[3] != 1) begin
         fails++; $display("[TB] FAIL b2b_pops: got %0d/%0d expected 3/1", popCnt[0], popCnt[3]);
      end
   endtask

   task automatic test_reset_mid_load();
      bit ok;
      int waited;
      startReset();
      releaseReset();
      addFrame(0, 1, 8'h11, 0);
      expectFrame(0, 0, 1, 8'h11, 1'b1, 1'b0);
      waitFrames(0, 300, ok);
      addFrame(2, 5, 8'h60, 4);
      expectFrame(2, 0, 5, 8'h60, 1'b1, 1'b0);
      waited = 0;
      while (popCnt[2] < 2 && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      reset_n = 1'b0;
      #1;
      tests += 6;
      if (!ok || waited >= 50) begin fails++; $display("[TB] FAIL midrst_setup: got waited %0d expected <50", waited); end
      if (src_pop !== 4'b0)       begin fails++; $display("[TB] FAIL midrst_pop: got %b expected 0", src_pop); end
      if (grant_id !== 2'd0)      begin fails++; $display("[TB] FAIL midrst_grant: got %0d expected 0", grant_id); end
      if (enc_din_valid !== 1'b0 || enc_din !== 8'h00) begin
         fails++; $display("[TB] FAIL midrst_din: got %b/%h expected 0/00", enc_din_valid, enc_din);
      end
      if (busy !== 1'b0)          begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
         fails++; $display("[TB] FAIL midrst_pulses: got %b/%b expected 0/0", frame_done, frame_err);
      end
      expBytes.delete();
      expFrames.delete();
      srcHead[2] = srcTail[2];
      addFrame(3, 1, 8'hA0, 0);
      addFrame(0, 1, 8'hB0, 0);
      expectFrame(0, 0, 1, 8'hB0, 1'b1, 1'b0);
      expectFrame(3, 0, 1, 8'hA0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      releaseReset();
      waitFrames(0, 1000, ok);
      tests++;
      if (!ok) begin fails++; $display("[TB] FAIL midrst_after: got pending %0d expected 0", expFrames.size()); end
   endtask

   initial begin
      reset_n       = 1'b0;
      encEn         = 1'b1;
      validCnt      = 0;
      validRuns     = 0;
      prevMonValid  = 1'b0;
      lastValidCycle = 0;
      lastEvtCycle  = 0;
      ind2Cycle     = 0;
      for (int i = 0; i < N; i++) begin
         srcHead[i] = 0;
         srcTail[i] = 0;
         popCnt[i]  = 0;
      end
      driveSources();
      test_reset();
      test_single_frame();
      test_round_robin_all();
      test_truncation();
      test_timeout();
      test_back_to_back();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
